light_monitor: RTL

LIGHT_MONITOR -- requirements
Module: light_monitor

---
 rtl/light_monitor_if.sv | 36 +++
 rtl/light_monitor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/light_monitor_if.sv
// light_monitor_if: bundles the light/walk code inputs, fault clear and monitor outputs.
//   master: drives light/walk codes and clear_faults, observes monitor outputs
//   slave : the monitor itself
interface light_monitor_if #(
    parameter int CNT_W = 32
);
    logic [2:0]       north_lights;
    logic [2:0]       north_left_lights;
    logic [2:0]       east_lights;
    logic [2:0]       east_left_lights;
    logic [2:0]       walk_north;
    logic [2:0]       walk_east;
    logic             clear_faults;
    logic [2:0]       phase;
    logic             conflict_fault;
    logic             code_fault;
    logic             seq_fault;
    logic             walk_fault;
    logic [7:0]       skip_count;
    logic [CNT_W-1:0] last_len;
    logic             len_valid;

    modport master (
        output north_lights, north_left_lights, east_lights, east_left_lights,
        output walk_north, walk_east, clear_faults,
        input  phase, conflict_fault, code_fault, seq_fault, walk_fault,
        input  skip_count, last_len, len_valid
    );

    modport slave (
        input  north_lights, north_left_lights, east_lights, east_left_lights,
        input  walk_north, walk_east, clear_faults,
        output phase, conflict_fault, code_fault, seq_fault, walk_fault,
        output skip_count, last_len, len_valid
    );
endinterface

// File: rtl/light_monitor.sv
// light_monitor: debounces traffic light/walk codes, decodes the phase and latches safety faults.
//   clk   : rising-edge clock
//   reset : asynchronous active-high reset
//   bus   : slave side of light_monitor_if (light/walk codes, clear_faults in;
//           phase, fault flags, skip_count, last_len, len_valid out)
module light_monitor #(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W = 32
) (
    input logic            clk,
    input logic            reset,
    light_monitor_if.slave bus
);
    typedef enum logic [2:0] {
        NS_GO = 3'b000, NS_YEL = 3'b001, EW_GO = 3'b010,
        EW_YEL = 3'b011, ALL_RED = 3'b100, INVALID = 3'b111
    } phase_t;
    typedef enum logic [1:0] {G_RED, G_GO, G_YEL, G_MIX} grp_t;

    localparam logic [17:0] ALL_STOP = {6{3'b100}};

    function automatic grp_t grp(input logic [2:0] a, input logic [2:0] b);
        logic g, y;
        g = (a == 3'b001) || (b == 3'b001);
        y = (a == 3'b010) || (b == 3'b010);
        return (a == 3'b100 && b == 3'b100) ? G_RED :
               (g && !y) ? G_GO : (y && !g) ? G_YEL : G_MIX;
    endfunction

    function automatic phase_t decode(input logic [17:0] v);
        grp_t ns, ew;
        ns = grp(v[17:15], v[14:12]);
        ew = grp(v[11:9], v[8:6]);
        return (ew == G_RED && ns == G_GO)  ? NS_GO :
               (ew == G_RED && ns == G_YEL) ? NS_YEL :
               (ns == G_RED && ew == G_GO)  ? EW_GO :
               (ns == G_RED && ew == G_YEL) ? EW_YEL :
               (ns == G_RED && ew == G_RED) ? ALL_RED : INVALID;
    endfunction

    function automatic logic legal(input phase_t a, input phase_t b);
        return (a == NS_GO && b == NS_YEL) || (a == EW_GO && b == EW_YEL) ||
               (a == NS_YEL && (b == EW_GO || b == ALL_RED)) ||
               (a == EW_YEL && (b == NS_GO || b == ALL_RED)) ||
               (a == ALL_RED && (b == NS_GO || b == EW_GO));
    endfunction

    function automatic logic lc_ok(input logic [2:0] c);
        return c == 3'b001 || c == 3'b010 || c == 3'b100;
    endfunction

    function automatic logic wc_ok(input logic [2:0] c);
        return c == 3'b010 || c == 3'b110 || c == 3'b100;
    endfunction

    logic [17:0]      raw, acc_q, acc_d, prev_q, prev_d;
    logic [7:0]       fcnt_q, fcnt_d, fnext, skip_q, skip_d;
    logic [CNT_W-1:0] dur_q, dur_d, dur_inc, last_len_q, last_len_d;
    logic             len_valid_q, len_valid_d;
    logic             conflict_q, conflict_d, code_q, code_d, seq_q, seq_d, walk_q, walk_d;
    phase_t           phase_cur, phase_new;
    logic             chg, both_valid, preempt, bad_seq, code_bad, conflict_set, walk_set;

    assign raw = {bus.north_lights, bus.north_left_lights, bus.east_lights,
                  bus.east_left_lights, bus.walk_north, bus.walk_east};

    always_comb begin
        // prev_q holds last edge's raw sample, so a run continues only while raw repeats
        fnext = (raw == prev_q && fcnt_q != 8'd0) ? fcnt_q + 8'd1 : 8'd1;
        prev_d = raw;
        acc_d = (raw != acc_q && fnext == 8'(STABLE_CYCLES)) ? raw : acc_q;
        fcnt_d = (raw == acc_q || fnext == 8'(STABLE_CYCLES)) ? 8'd0 : fnext;
        // all checks look at the vector being accepted this edge, so faults line up with phase
        phase_cur = decode(acc_q);
        phase_new = decode(acc_d);
        chg = phase_new != phase_cur;
        both_valid = phase_cur != INVALID && phase_new != INVALID;
        preempt = chg && both_valid && !legal(phase_cur, phase_new) &&
                  (phase_new == NS_GO || phase_new == EW_GO);
        bad_seq = chg && both_valid && !legal(phase_cur, phase_new) && !preempt;
        code_bad = !lc_ok(acc_d[17:15]) || !lc_ok(acc_d[14:12]) || !lc_ok(acc_d[11:9]) ||
                   !lc_ok(acc_d[8:6]) || !wc_ok(acc_d[5:3]) || !wc_ok(acc_d[2:0]);
        conflict_set = !code_bad && grp(acc_d[17:15], acc_d[14:12]) != G_RED &&
                       grp(acc_d[11:9], acc_d[8:6]) != G_RED;
        walk_set = ((acc_d[5:3] == 3'b010 || acc_d[5:3] == 3'b110) &&
                    phase_new != NS_GO && phase_new != NS_YEL) ||
                   ((acc_d[2:0] == 3'b010 || acc_d[2:0] == 3'b110) &&
                    phase_new != EW_GO && phase_new != EW_YEL);
        conflict_d = conflict_set || (conflict_q && !bus.clear_faults);
        code_d = code_bad || (code_q && !bus.clear_faults);
        seq_d = bad_seq || (seq_q && !bus.clear_faults);
        walk_d = walk_set || (walk_q && !bus.clear_faults);
        skip_d = preempt ? (bus.clear_faults ? 8'd1 : (&skip_q ? skip_q : skip_q + 8'd1)) :
                 (bus.clear_faults ? 8'd0 : skip_q);
        dur_inc = &dur_q ? dur_q : dur_q + 1'b1;
        dur_d = chg ? '0 : dur_inc;
        last_len_d = chg ? dur_inc : last_len_q;
        len_valid_d = chg;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q       <= ALL_STOP;
            prev_q      <= ALL_STOP;
            fcnt_q      <= '0;
            skip_q      <= '0;
            dur_q       <= '0;
            last_len_q  <= '0;
            len_valid_q <= 1'b0;
            conflict_q  <= 1'b0;
            code_q      <= 1'b0;
            seq_q       <= 1'b0;
            walk_q      <= 1'b0;
        end else begin
            acc_q       <= acc_d;
            prev_q      <= prev_d;
            fcnt_q      <= fcnt_d;
            skip_q      <= skip_d;
            dur_q       <= dur_d;
            last_len_q  <= last_len_d;
            len_valid_q <= len_valid_d;
            conflict_q  <= conflict_d;
            code_q      <= code_d;
            seq_q       <= seq_d;
            walk_q      <= walk_d;
        end
    end

    assign bus.phase          = phase_cur;
    assign bus.conflict_fault = conflict_q;
    assign bus.code_fault     = code_q;
    assign bus.seq_fault      = seq_q;
    assign bus.walk_fault     = walk_q;
    assign bus.skip_count     = skip_q;
    assign bus.last_len       = last_len_q;
    assign bus.len_valid      = len_valid_q;
endmodule
